// File: rtl/reg_file_sb_if.sv
// Operand/write-back/special-register bundle between decode,
// write-back and the register file with scoreboard.
interface reg_file_sb_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int NUM_RD  = 2,
    parameter int NUM_SPC = 4,
    parameter int SPC_W   = 2
);
    localparam int NREGS = 1 << ADDR_W;

    logic [NUM_RD*ADDR_W-1:0]  rd_addr;
    logic [NUM_RD*DATA_W-1:0]  rd_data;
    logic [NUM_RD-1:0]         rd_busy;
    logic                      issue_en;
    logic [ADDR_W-1:0]         issue_dst;
    logic                      issue_ok;
    logic                      wb_en;
    logic [ADDR_W-1:0]         wb_addr;
    logic [DATA_W-1:0]         wb_data;
    logic                      spc_we;
    logic [SPC_W-1:0]          spc_sel;
    logic [DATA_W-1:0]         spc_wdata;
    logic [NUM_SPC*DATA_W-1:0] spc_data;
    logic                      flush;
    logic [NREGS-1:0]          busy_vec;

    modport master (
        output rd_addr, issue_en, issue_dst,
        output wb_en, wb_addr, wb_data,
        output spc_we, spc_sel, spc_wdata, flush,
        input  rd_data, rd_busy, issue_ok,
        input  spc_data, busy_vec
    );

    modport slave (
        input  rd_addr, issue_en, issue_dst,
        input  wb_en, wb_addr, wb_data,
        input  spc_we, spc_sel, spc_wdata, flush,
        output rd_data, rd_busy, issue_ok,
        output spc_data, busy_vec
    );
endinterface

// File: rtl/reg_file_sb.sv
// GPR file with bypassed read ports, busy scoreboard for RAW/WAW
// detection and a small bypassed special-register bank.
module reg_file_sb #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int NUM_RD  = 2,
    parameter int NUM_SPC = 4,
    parameter int SPC_W   = 2
) (
    input logic          clk_50MHz,
    input logic          rst,
    reg_file_sb_if.slave bus
);
    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] spc  [NUM_SPC];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;

    logic wb_live;
    logic spc_live;
    logic spc_valid;
    logic issue_hit;
    logic issue_ok;

    // Bypasses are masked in reset so outputs reflect only the zeroed state.
    assign wb_live   = bus.wb_en && !rst;
    assign spc_valid = (32'(bus.spc_sel) < NUM_SPC);
    assign spc_live  = bus.spc_we && spc_valid && !rst;

    assign issue_hit = wb_live && (bus.wb_addr == bus.issue_dst);
    assign issue_ok  = !busy[bus.issue_dst] || issue_hit;

    assign bus.issue_ok = issue_ok;
    assign bus.busy_vec = busy;

    always_comb begin
        busy_nxt = busy;
        if (bus.wb_en)
            busy_nxt[bus.wb_addr] = 1'b0;
        if (bus.issue_en && issue_ok)
            busy_nxt[bus.issue_dst] = 1'b1;
        if (bus.flush)
            busy_nxt = '0;
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
            for (int s = 0; s < NUM_SPC; s++)
                spc[s] <= '0;
            busy <= '0;
        end else begin
            if (bus.wb_en)
                regs[bus.wb_addr] <= bus.wb_data;
            for (int s = 0; s < NUM_SPC; s++)
                if (bus.spc_we && 32'(bus.spc_sel) == s)
                    spc[s] <= bus.spc_wdata;
            busy <= busy_nxt;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit;

        assign addr = bus.rd_addr[i*ADDR_W +: ADDR_W];
        assign hit  = wb_live && (bus.wb_addr == addr);

        assign bus.rd_data[i*DATA_W +: DATA_W] =
            hit ? bus.wb_data : regs[addr];
        assign bus.rd_busy[i] = hit ? 1'b0 : busy[addr];
    end

    for (genvar k = 0; k < NUM_SPC; k++) begin : g_spc
        logic hit;

        assign hit = spc_live && (32'(bus.spc_sel) == k);
        assign bus.spc_data[k*DATA_W +: DATA_W] =
            hit ? bus.spc_wdata : spc[k];
    end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised general-purpose register file with multiple read ports, write-back bypass, a per-register busy scoreboard and a generic special-register bank.
- Sits between decode and write-back.
- Decode reads operands and reserves destinations; write-back commits results and releases reservations.
- Lets the pipeline detect RAW/WAW hazards without a separate hazard table.

Parameters:
DATA_W, 16, data width of every register
ADDR_W, 3, GPR address width; NREGS = 2**ADDR_W
NUM_RD, 2, number of GPR read ports
NUM_SPC, 4, number of special registers (T, SP, IH, RA at indices 0..3 by default)
SPC_W, 2, special-register select width; must be at least clog2(NUM_SPC)

Ports:
clk_50MHz  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data
rd_busy  out  NUM_RD  1 = addressed register has an outstanding reservation after bypass
issue_en  in  1  reserve issue_dst this cycle
issue_dst  in  ADDR_W  destination to reserve
issue_ok  out  1  reservation would be accepted (combinational)
wb_en  in  1  GPR write-back strobe
wb_addr  in  ADDR_W  GPR write address
wb_data  in  DATA_W  GPR write data
spc_we  in  1  special-register write strobe
spc_sel  in  SPC_W  special-register index
spc_wdata  in  DATA_W  special-register write data
spc_data  out  NUM_SPC*DATA_W  packed special-register contents, bypassed
flush  in  1  clear all reservations
busy_vec  out  NREGS  raw scoreboard bits

Behaviour:
Reset:
- On rst high, asynchronously zero all GPRs, special registers and busy bits.
- While rst is high, every output is the combinational function of the zeroed state: rd_data=0, rd_busy=0, spc_data=0, busy_vec=0, and issue_ok=1 when issue_en=1.
- Reset asserted mid-operation discards pending reservations and writes in that cycle.

Read path:
- Combinational, zero latency.
- Default: rd_data[i] = regs[rd_addr[i]].
- Bypass: if wb_en and wb_addr==rd_addr[i], then rd_data[i]=wb_data and rd_busy[i]=0.
- Otherwise rd_busy[i]=busy[rd_addr[i]].

Special registers:
- spc_data[k] = spc[k], except it equals spc_wdata when spc_we and spc_sel==k.
- spc_sel >= NUM_SPC: write ignored, no state change.

Write-back (rising edge, wb_en=1):
- regs[wb_addr] <= wb_data.
- busy[wb_addr] <= 0, unless overridden by issue below.
- wb_en to a non-busy register is legal: data is written, busy stays 0.

Issue:
- issue_ok = !busy[issue_dst] || (wb_en && wb_addr==issue_dst).
- WAW protection: a destination with an outstanding reservation is refused.
- issue_ok is driven regardless of issue_en.
- On a rising edge with issue_en && issue_ok && !flush: busy[issue_dst] <= 1.
- issue_en with issue_ok=0: no state change; the pipeline must stall and retry.

Priority for a single busy bit in the same cycle, highest first:
1. flush
2. issue set
3. wb clear
- Hence wb and issue to the same address leaves busy=1 and writes the data.

Flush:
- Clears all busy bits at the edge.
- Does not block a concurrent wb_en data write or spc_we.
- Does not alter register contents.

Multiple read ports:
- Ports may address the same register; each port resolves independently.

Widths: no arithmetic; all data paths pass DATA_W bits unchanged.

Test Plan:
1. Reset then read: pulse rst with clock stopped -> all rd_data=0, busy_vec=0, spc_data=0; write-back r3=0x1234; next cycle rd_addr0=3 -> rd_data0=0x1234.
2. Bypass: wb_en, wb_addr=5, wb_data=0xBEEF, rd_addr1=5 in the same cycle -> rd_data1=0xBEEF and rd_busy1=0 before the edge; after the edge, regs[5]=0xBEEF.
3. Scoreboard/WAW: issue r2 -> busy_vec=0x04 and a read of r2 gives rd_busy=1; re-issue r2 -> issue_ok=0, busy unchanged; wb r2=0x0007 with concurrent issue r2 -> issue_ok=1, busy stays 1, regs[2]=7; wb r2 alone -> busy_vec=0.
4. Flush priority: busy r1, r4 set; in one cycle assert flush, issue r6 and wb r1=0x55AA -> busy_vec=0 and regs[1]=0x55AA.
5. Special regs: spc_we, spc_sel=1, spc_wdata=0xFFFE -> spc_data SP slice=0xFFFE combinationally and after the edge; spc_sel=3 write of 0x0100 leaves index 1 unchanged.
6. Async reset mid-operation: with busy bits set and wb_en active, assert rst between clock edges -> outputs zero immediately, and no write occurs on the following edge while rst is high.
